// File: rtl/painterengine_gpu_reader_fifo_if.sv
// Word stream bundle around the reader FIFO: reader-side beats in, pixel-pipeline beats out.
// Handshake: a beat moves on a clock edge only when its valid and its next/ready are both 1 at that edge.
interface painterengine_gpu_reader_fifo_if #(
  parameter int PARAM_DATA_WIDTH = 32
);
  logic [PARAM_DATA_WIDTH-1:0] i_wire_data;
  logic                        i_wire_data_valid;
  logic                        o_wire_data_next;
  logic [PARAM_DATA_WIDTH-1:0] o_wire_data;
  logic                        o_wire_data_valid;
  logic                        i_wire_data_ready;

  modport master (
    output i_wire_data, i_wire_data_valid, i_wire_data_ready,
    input  o_wire_data_next, o_wire_data, o_wire_data_valid
  );

  modport slave (
    input  i_wire_data, i_wire_data_valid, i_wire_data_ready,
    output o_wire_data_next, o_wire_data, o_wire_data_valid
  );
endinterface

// File: rtl/painterengine_gpu_reader_fifo.sv
// GPU DMA reader output stage: first-word-fall-through FIFO with length tracking,
// done/error reporting and a flush on reader error or short transfer.
module painterengine_gpu_reader_fifo #(
  parameter int PARAM_DATA_WIDTH = 32,
  parameter int PARAM_DEPTH_LOG2 = 6
) (
  input  logic                      i_wire_clock,
  input  logic                      i_wire_resetn,
  input  logic                      i_wire_start,
  input  logic [31:0]               i_wire_length,
  input  logic                      i_wire_reader_done,
  input  logic                      i_wire_reader_error,
  painterengine_gpu_reader_fifo_if.slave bus,
  output logic [PARAM_DEPTH_LOG2:0] o_wire_level,
  output logic                      o_wire_busy,
  output logic                      o_wire_done,
  output logic                      o_wire_error,
  output logic [1:0]                o_wire_state
);

  localparam int DEPTH = 1 << PARAM_DEPTH_LOG2;
  localparam logic [PARAM_DEPTH_LOG2:0]   LEVEL_FULL = (PARAM_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [PARAM_DEPTH_LOG2:0]   LEVEL_ONE  = (PARAM_DEPTH_LOG2+1)'(1);
  localparam logic [PARAM_DEPTH_LOG2-1:0] PTR_ONE    = PARAM_DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  state_t                      state;
  logic [PARAM_DEPTH_LOG2-1:0] wr_ptr;
  logic [PARAM_DEPTH_LOG2-1:0] rd_ptr;
  logic [PARAM_DEPTH_LOG2:0]   level;
  logic [31:0]                 in_count;
  logic [31:0]                 out_count;
  logic [31:0]                 length_q;
  logic [PARAM_DATA_WIDTH-1:0] mem [DEPTH];

  logic data_next;
  logic out_valid;
  logic wr_fire;
  logic rd_fire;

  // Space is judged on registered level only; a same-cycle read never frees a slot for a write.
  assign data_next = (state == ST_RUN) && (level < LEVEL_FULL) && (in_count < length_q);
  assign out_valid = (state == ST_RUN) && (level != '0);
  assign wr_fire   = bus.i_wire_data_valid && data_next;
  assign rd_fire   = out_valid && bus.i_wire_data_ready;

  assign bus.o_wire_data_next  = data_next;
  assign bus.o_wire_data_valid = out_valid;
  assign bus.o_wire_data       = mem[rd_ptr];

  assign o_wire_level = level;
  assign o_wire_busy  = (state == ST_RUN);
  assign o_wire_done  = (state == ST_DONE);
  assign o_wire_error = (state == ST_ERROR);
  assign o_wire_state = state;

  always_ff @(posedge i_wire_clock) begin
    if (wr_fire) begin
      mem[wr_ptr] <= bus.i_wire_data;
    end
  end

  always_ff @(posedge i_wire_clock) begin
    if (!i_wire_resetn) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_count  <= '0;
      out_count <= '0;
      length_q  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (i_wire_reader_error ||
              (i_wire_reader_done && (in_count < length_q) && !wr_fire)) begin
            state  <= ST_ERROR;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
          end else begin
            if (wr_fire) begin
              wr_ptr   <= wr_ptr + PTR_ONE;
              in_count <= in_count + 32'd1;
            end
            if (rd_fire) begin
              rd_ptr    <= rd_ptr + PTR_ONE;
              out_count <= out_count + 32'd1;
            end
            if (wr_fire && !rd_fire) begin
              level <= level + LEVEL_ONE;
            end else if (rd_fire && !wr_fire) begin
              level <= level - LEVEL_ONE;
            end
            if (rd_fire && (out_count + 32'd1 == length_q)) begin
              state <= ST_DONE;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERROR all re-arm on start the same way.
          if (i_wire_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            in_count  <= '0;
            out_count <= '0;
            if (i_wire_length == 32'd0) begin
              state <= ST_ERROR;
            end else begin
              length_q <= i_wire_length;
              state    <= ST_RUN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_reader_fifo.sv
// Directed bench for the reader FIFO: ordered delivery, backpressure, wrap, error,
// short transfer and mid-transfer reset.
module tb_painterengine_gpu_reader_fifo;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [31:0] length;
  logic        reader_done;
  logic        reader_error;
  logic [6:0]  level;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [31:0] exp_q[$];

  painterengine_gpu_reader_fifo_if #(.PARAM_DATA_WIDTH(32)) bus ();

  painterengine_gpu_reader_fifo #(
    .PARAM_DATA_WIDTH(32),
    .PARAM_DEPTH_LOG2(6)
  ) dut (
    .i_wire_clock       (clk),
    .i_wire_resetn      (resetn),
    .i_wire_start       (start),
    .i_wire_length      (length),
    .i_wire_reader_done (reader_done),
    .i_wire_reader_error(reader_error),
    .bus                (bus.slave),
    .o_wire_level       (level),
    .o_wire_busy        (busy),
    .o_wire_done        (done),
    .o_wire_error       (error),
    .o_wire_state       (state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock: account for beats that fire at the coming edge, then step past it.
  task automatic tick();
    if (bus.o_wire_data_valid && bus.i_wire_data_ready) begin
      if (exp_q.size() == 0) check("rd_underflow", 32'(exp_q.size()), 32'd1);
      else check("rd_data", bus.o_wire_data, exp_q.pop_front());
      rd_cnt++;
    end
    if (bus.i_wire_data_valid && bus.o_wire_data_next) begin
      exp_q.push_back(bus.i_wire_data);
      wr_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [31:0] len);
    wr_cnt = 0;
    rd_cnt = 0;
    exp_q.delete();
    bus.i_wire_data_valid = 1'b0;
    start  = 1'b1;
    length = len;
    tick();
    start = 1'b0;
  endtask

  // Feed pattern base+i up to n words with the consumer ready set, until done or budget.
  task automatic run_to_done(input int n, input logic [31:0] base, input int budget);
    bus.i_wire_data_ready = 1'b1;
    for (int c = 0; c < budget && !done; c++) begin
      bus.i_wire_data_valid = (wr_cnt < n);
      bus.i_wire_data       = base + 32'(wr_cnt);
      tick();
    end
    bus.i_wire_data_valid = 1'b0;
  endtask

  initial begin
    int prev_w;
    resetn = 1'b0;
    start = 1'b0;
    length = '0;
    reader_done = 1'b0;
    reader_error = 1'b0;
    bus.i_wire_data = '0;
    bus.i_wire_data_valid = 1'b0;
    bus.i_wire_data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_flags", {27'd0, busy, done, error, bus.o_wire_data_valid, bus.o_wire_data_next}, 32'd0);
    resetn = 1'b1;
    tick();

    // Five words 0x11..0x55 straight through.
    start_xfer(32'd5);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_next", 32'(bus.o_wire_data_next), 32'd1);
    check("t1_valid0", 32'(bus.o_wire_data_valid), 32'd0);
    bus.i_wire_data_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      bus.i_wire_data_valid = (wr_cnt < 5);
      bus.i_wire_data       = 32'h11 * 32'(wr_cnt + 1);
      prev_w = wr_cnt;
      tick();
      if (prev_w == 0 && wr_cnt == 1) begin
        check("t1_fwft_valid", 32'(bus.o_wire_data_valid), 32'd1);
        check("t1_fwft_data", bus.o_wire_data, 32'h11);
      end
      if (prev_w == 4 && wr_cnt == 5) check("t1_next_off", 32'(bus.o_wire_data_next), 32'd0);
      if (rd_cnt == 5) break;
    end
    bus.i_wire_data_valid = 1'b0;
    check("t1_done", 32'(done), 32'd1);
    check("t1_rd_cnt", 32'(rd_cnt), 32'd5);
    check("t1_valid_off", 32'(bus.o_wire_data_valid), 32'd0);

    // 100 words against a stalled consumer, then drain through the pointer wrap.
    start_xfer(32'd100);
    bus.i_wire_data_ready = 1'b0;
    for (int c = 0; c < 70; c++) begin
      bus.i_wire_data_valid = 1'b1;
      bus.i_wire_data       = 32'h1000 + 32'(wr_cnt);
      tick();
    end
    check("t2_wr64", 32'(wr_cnt), 32'd64);
    check("t2_level64", 32'(level), 32'd64);
    check("t2_next_full", 32'(bus.o_wire_data_next), 32'd0);
    bus.i_wire_data_ready = 1'b1;
    bus.i_wire_data       = 32'h1000 + 32'(wr_cnt);
    tick();
    check("t3_level63", 32'(level), 32'd63);
    check("t3_no_write", 32'(wr_cnt), 32'd64);
    check("t3_next_back", 32'(bus.o_wire_data_next), 32'd1);
    run_to_done(100, 32'h1000, 200);
    check("t2_done", 32'(done), 32'd1);
    check("t2_rd_cnt", 32'(rd_cnt), 32'd100);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Reader error after four words flushes; a new start recovers.
    start_xfer(32'd10);
    bus.i_wire_data_ready = 1'b0;
    for (int c = 0; c < 20 && wr_cnt < 4; c++) begin
      bus.i_wire_data_valid = 1'b1;
      bus.i_wire_data       = 32'h2000 + 32'(wr_cnt);
      tick();
    end
    bus.i_wire_data_valid = 1'b0;
    check("t4_level4", 32'(level), 32'd4);
    reader_error = 1'b1;
    tick();
    reader_error = 1'b0;
    check("t4_error", 32'(error), 32'd1);
    check("t4_valid", 32'(bus.o_wire_data_valid), 32'd0);
    check("t4_level", 32'(level), 32'd0);
    check("t4_next", 32'(bus.o_wire_data_next), 32'd0);
    tick();
    check("t4_sticky", 32'(error), 32'd1);
    start_xfer(32'd3);
    check("t4_rearm", 32'(busy), 32'd1);
    run_to_done(3, 32'h3000, 20);
    check("t4_done", 32'(done), 32'd1);
    check("t4_rd_cnt", 32'(rd_cnt), 32'd3);

    // Short transfer: reader signals done after six of eight words.
    start_xfer(32'd8);
    bus.i_wire_data_ready = 1'b1;
    for (int c = 0; c < 20 && wr_cnt < 6; c++) begin
      bus.i_wire_data_valid = 1'b1;
      bus.i_wire_data       = 32'h4000 + 32'(wr_cnt);
      tick();
    end
    bus.i_wire_data_valid = 1'b0;
    tick();
    tick();
    check("t5_rd_cnt", 32'(rd_cnt), 32'd6);
    check("t5_still_busy", 32'(busy), 32'd1);
    reader_done = 1'b1;
    tick();
    reader_done = 1'b0;
    check("t5_error", 32'(error), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);

    // Reset in the middle of a transfer with seven words buffered.
    start_xfer(32'd20);
    bus.i_wire_data_ready = 1'b0;
    for (int c = 0; c < 20 && wr_cnt < 7; c++) begin
      bus.i_wire_data_valid = 1'b1;
      bus.i_wire_data       = 32'h5000 + 32'(wr_cnt);
      tick();
    end
    bus.i_wire_data_valid = 1'b0;
    check("t6_level7", 32'(level), 32'd7);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("t6_state", 32'(state), 32'd0);
    check("t6_level", 32'(level), 32'd0);
    check("t6_flags", {27'd0, busy, done, error, bus.o_wire_data_valid, bus.o_wire_data_next}, 32'd0);

    // Zero length straight from IDLE, then a normal transfer.
    start_xfer(32'd0);
    check("t7_len0_error", 32'(error), 32'd1);
    check("t7_len0_busy", 32'(busy), 32'd0);
    start_xfer(32'd4);
    check("t7_busy", 32'(busy), 32'd1);
    run_to_done(4, 32'h6000, 20);
    check("t7_done", 32'(done), 32'd1);
    check("t7_rd_cnt", 32'(rd_cnt), 32'd4);
    check("t7_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
